anita3_scaler_readout: RTL and testbench

- Downstream consumer of the ANITA3 scaler bank.
- After each PPS it walks the scaler bank's address space, captures every 32-bit word into a double-buffered frame RAM, then posts a complete frame to the host/event-builder side with a valid/ack handshake.
- Gives the host an atomic one-second snapshot of L1, L3, L3-mon, refpulse, sec/deadtime and C3PO words, instead of live reads that can straddle a PPS latch.

---
 rtl/anita3_scaler_readout.sv | 184 ++++++++++++++++++
 tb/tb_anita3_scaler_readout.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/anita3_scaler_readout.sv
// ANITA3 scaler readout: on each PPS, captures the scaler bank into a double-buffered frame RAM and posts it to the host.
// Optional soft trigger input enabled by defining SCALER_READOUT_SOFT_TRIG_EN.
module anita3_scaler_readout #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SEQ_WIDTH     = 16
) (
  input  logic        clk33_i,
  input  logic        rst_i,
  input  logic        pps_i,
  output logic [5:0]  scal_addr_o,
  input  logic [31:0] scal_dat_i,
  output logic        frame_valid_o,
  input  logic        frame_ack_i,
  input  logic [5:0]  rd_addr_i,
  output logic [31:0] rd_dat_o,
  output logic        busy_o,
  output logic [7:0]  drop_cnt_o
`ifdef SCALER_READOUT_SOFT_TRIG_EN
  ,
  input  logic        soft_trig_i
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, SCAN, COMMIT} state_t;

  localparam logic [5:0] LAST_WORD   = 6'd34;
  localparam logic [5:0] HEADER_WORD = 6'd35;

  state_t               state;
  logic                 pps_q;
  logic [3:0]           settle_cnt;
  logic [5:0]           idx;
  logic [31:0]          dat_q;
  logic [5:0]           widx_q;
  logic                 wr_pend;
  logic                 wbank;
  logic [SEQ_WIDTH-1:0] seq;
  logic [15:0]          seq16;
  logic [7:0]           frame_tag;

  logic                 pps_edge;
  logic                 start;
  logic                 pps_ignored;
  logic                 commit_ok;
  logic                 drop_frame;
  logic [8:0]           drop_sum;
  logic [7:0]           drop_next;

  logic [31:0]          ram [0:127];
  logic                 we;
  logic [6:0]           waddr;
  logic [31:0]          wdata;

  function automatic logic [5:0] scan_addr(input logic [5:0] i);
    if (i < 6'd32)       return i;
    else if (i == 6'd32) return 6'h20;
    else if (i == 6'd33) return 6'h21;
    else                 return 6'h27;
  endfunction

  generate
    if (SEQ_WIDTH >= 16) begin : g_seq_trunc
      assign seq16 = seq[15:0];
    end else begin : g_seq_ext
      assign seq16 = {{(16 - SEQ_WIDTH){1'b0}}, seq};
    end
  endgenerate

  assign pps_edge    = pps_i & ~pps_q;
  assign pps_ignored = pps_edge && (state != IDLE);
  assign commit_ok   = (state == COMMIT) && (!frame_valid_o || frame_ack_i);
  assign drop_frame  = (state == COMMIT) && !commit_ok;
  assign drop_sum    = {1'b0, drop_cnt_o} + {8'd0, pps_ignored} + {8'd0, drop_frame};
  assign drop_next   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

`ifdef SCALER_READOUT_SOFT_TRIG_EN
  assign start = pps_edge | soft_trig_i;

  // A simultaneous PPS edge wins, so the frame is tagged as a PPS frame.
  always_ff @(posedge clk33_i) begin
    if (rst_i)
      frame_tag <= 8'hA3;
    else if (state == IDLE && start)
      frame_tag <= (soft_trig_i && !pps_edge) ? 8'hA5 : 8'hA3;
  end
`else
  assign start     = pps_edge;
  assign frame_tag = 8'hA3;
`endif

  // pps_q tracks through reset so a PPS level held across reset is not seen as a fresh edge.
  always_ff @(posedge clk33_i) begin
    pps_q <= pps_i;
  end

  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      idx           <= '0;
      scal_addr_o   <= '0;
      busy_o        <= 1'b0;
      frame_valid_o <= 1'b0;
      drop_cnt_o    <= '0;
      seq           <= '0;
      wbank         <= 1'b0;
      wr_pend       <= 1'b0;
      widx_q        <= '0;
      dat_q         <= '0;
    end else begin
      drop_cnt_o <= drop_next;
      wr_pend    <= 1'b0;
      if (frame_ack_i && frame_valid_o)
        frame_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            settle_cnt <= 4'(SETTLE_CYCLES - 1);
            busy_o     <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state       <= SCAN;
            idx         <= '0;
            scal_addr_o <= 6'h00;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SCAN: begin
          // Capture this cycle's word; it lands in RAM one edge later. idx==35 is the drain cycle.
          if (idx <= LAST_WORD) begin
            dat_q       <= scal_dat_i;
            widx_q      <= idx;
            wr_pend     <= 1'b1;
            idx         <= idx + 6'd1;
            scal_addr_o <= scan_addr(idx + 6'd1);
          end else begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          if (commit_ok) begin
            wbank         <= ~wbank;
            frame_valid_o <= 1'b1;
          end
          seq         <= seq + 1'b1;
          state       <= IDLE;
          busy_o      <= 1'b0;
          scal_addr_o <= 6'h00;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    we    = !rst_i && (wr_pend || state == COMMIT);
    waddr = {wbank, widx_q};
    wdata = dat_q;
    if (state == COMMIT) begin
      waddr = {wbank, HEADER_WORD};
      wdata = {seq16, drop_cnt_o, frame_tag};
    end
  end

  always_ff @(posedge clk33_i) begin
    if (we)
      ram[waddr] <= wdata;
  end

  // Only the read bank is read, so this data never changes while a scan fills the other bank.
  always_ff @(posedge clk33_i) begin
    if (rst_i)
      rd_dat_o <= '0;
    else if (rd_addr_i <= HEADER_WORD)
      rd_dat_o <= ram[{~wbank, rd_addr_i}];
    else
      rd_dat_o <= '0;
  end

endmodule

// File: tb/tb_anita3_scaler_readout.sv
// Directed self-checking bench for anita3_scaler_readout; soft-trigger case builds only with SCALER_READOUT_SOFT_TRIG_EN.
module tb_anita3_scaler_readout;

  logic        clk33 = 1'b0;
  logic        rst = 1'b0;
  logic        pps = 1'b0;
  logic [5:0]  scal_addr;
  logic [31:0] scal_dat;
  logic        frame_valid;
  logic        frame_ack = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [31:0] rd_dat;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [15:0] gen = '0;
`ifdef SCALER_READOUT_SOFT_TRIG_EN
  logic        soft_trig = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [10];

  always #5 clk33 = ~clk33;

  // Scaler model: upper bits carry the address, low bits tag which scan produced the word.
  assign scal_dat = {scal_addr, 10'h000, gen};

  anita3_scaler_readout #(.SETTLE_CYCLES(4), .SEQ_WIDTH(16)) dut (
    .clk33_i      (clk33),
    .rst_i        (rst),
    .pps_i        (pps),
    .scal_addr_o  (scal_addr),
    .scal_dat_i   (scal_dat),
    .frame_valid_o(frame_valid),
    .frame_ack_i  (frame_ack),
    .rd_addr_i    (rd_addr),
    .rd_dat_o     (rd_dat),
    .busy_o       (busy),
    .drop_cnt_o   (drop_cnt)
`ifdef SCALER_READOUT_SOFT_TRIG_EN
    ,
    .soft_trig_i  (soft_trig)
`endif
  );

  function automatic logic [5:0] expAddr(input int i);
    if (i < 32)       return 6'(i);
    else if (i == 32) return 6'h20;
    else if (i == 33) return 6'h21;
    else              return 6'h27;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk33);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input rd_vec_t v);
    rd_addr = v.addr;
    tick();
    checkOutput($sformatf("rd_word%0d", v.addr), rd_dat, v.exp);
  endtask

  task automatic readCheck(input string name, input logic [5:0] a, input logic [31:0] exp);
    rd_addr = a;
    tick();
    checkOutput(name, rd_dat, exp);
  endtask

  task automatic pulsePps();
    pps = 1'b1;
    tick();
    pps = 1'b0;
  endtask

  task automatic pulseAck();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    checkOutput(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{6'd0,  32'h0000_0000};
    vecs[1] = '{6'd1,  32'h0400_0000};
    vecs[2] = '{6'd17, 32'h4400_0000};
    vecs[3] = '{6'd31, 32'h7C00_0000};
    vecs[4] = '{6'd32, 32'h8000_0000};
    vecs[5] = '{6'd33, 32'h8400_0000};
    vecs[6] = '{6'd34, 32'h9C00_0000};
    vecs[7] = '{6'd35, 32'h0000_00A3};
    vecs[8] = '{6'd36, 32'h0000_0000};
    vecs[9] = '{6'd63, 32'h0000_0000};

    rst = 1'b1;
    tick(3);
    checkOutput("rst_scal_addr", {26'd0, scal_addr}, 32'd0);
    checkOutput("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    checkOutput("rst_rd_dat", rd_dat, 32'd0);
    rst = 1'b0;
    tick(2);

    $display("[TB] first frame");
    gen = 16'd0;
    pulsePps();
    checkOutput("settle_busy", {31'd0, busy}, 32'd1);
    tick(4);
    for (int i = 0; i < 35; i++) begin
      checkOutput($sformatf("scan_addr%0d", i), {26'd0, scal_addr}, {26'd0, expAddr(i)});
      tick();
    end
    tick();
    checkOutput("commit_busy", {31'd0, busy}, 32'd1);
    checkOutput("commit_valid_low", {31'd0, frame_valid}, 32'd0);
    tick();
    checkOutput("frame1_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("frame1_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    $display("[TB] second PPS without ack");
    gen = 16'd1;
    pulsePps();
    waitIdle("frame2_timeout", 60);
    checkOutput("frame2_valid_held", {31'd0, frame_valid}, 32'd1);
    checkOutput("frame2_drop", {24'd0, drop_cnt}, 32'd1);
    readCheck("frame2_word1_unchanged", 6'd1, 32'h0400_0000);
    readCheck("frame2_hdr_unchanged", 6'd35, 32'h0000_00A3);
    pulseAck();
    checkOutput("ack_clears_valid", {31'd0, frame_valid}, 32'd0);
    gen = 16'd2;
    pulsePps();
    waitIdle("frame3_timeout", 60);
    checkOutput("frame3_valid", {31'd0, frame_valid}, 32'd1);
    readCheck("frame3_hdr", 6'd35, 32'h0002_01A3);
    readCheck("frame3_word1", 6'd1, 32'h0400_0002);

    $display("[TB] PPS during scan");
    pulseAck();
    gen = 16'd3;
    pulsePps();
    tick(10);
    pulsePps();
    checkOutput("scan_pps_drop", {24'd0, drop_cnt}, 32'd2);
    waitIdle("frame4_timeout", 60);
    checkOutput("frame4_valid", {31'd0, frame_valid}, 32'd1);
    tick(10);
    checkOutput("no_second_scan", {31'd0, busy}, 32'd0);
    readCheck("frame4_hdr", 6'd35, 32'h0003_02A3);
    readCheck("frame4_word0", 6'd0, 32'h0000_0003);

    $display("[TB] reset mid-scan");
    gen = 16'd9;
    pulsePps();
    tick(14);
    checkOutput("midscan_addr10", {26'd0, scal_addr}, 32'd10);
    rst = 1'b1;
    tick();
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_scal_addr", {26'd0, scal_addr}, 32'd0);
    checkOutput("midrst_valid", {31'd0, frame_valid}, 32'd0);
    rst = 1'b0;
    tick(2);
    gen = 16'd4;
    pulsePps();
    waitIdle("frame5_timeout", 60);
    checkOutput("frame5_valid", {31'd0, frame_valid}, 32'd1);
    readCheck("frame5_hdr", 6'd35, 32'h0000_00A3);
    readCheck("frame5_word5", 6'd5, 32'h1400_0004);
    readCheck("frame5_word34", 6'd34, 32'h9C00_0004);

    $display("[TB] ack in commit cycle");
    gen = 16'd5;
    pulsePps();
    tick(40);
    checkOutput("pre_commit_busy", {31'd0, busy}, 32'd1);
    checkOutput("pre_commit_valid", {31'd0, frame_valid}, 32'd1);
    pulseAck();
    checkOutput("commit_ack_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("commit_ack_drop", {24'd0, drop_cnt}, 32'd0);
    readCheck("frame6_hdr", 6'd35, 32'h0001_00A3);
    readCheck("frame6_word2", 6'd2, 32'h0800_0005);

    $display("[TB] drop counter saturation");
    gen = 16'd6;
    for (int i = 0; i < 300; i++) begin
      pulsePps();
      waitIdle($sformatf("sat_timeout%0d", i), 60);
    end
    checkOutput("drop_saturated", {24'd0, drop_cnt}, 32'd255);
    checkOutput("sat_valid_held", {31'd0, frame_valid}, 32'd1);
    readCheck("sat_hdr_unchanged", 6'd35, 32'h0001_00A3);

`ifdef SCALER_READOUT_SOFT_TRIG_EN
    $display("[TB] soft trigger");
    pulseAck();
    gen = 16'd7;
    soft_trig = 1'b1;
    tick();
    soft_trig = 1'b0;
    checkOutput("soft_busy", {31'd0, busy}, 32'd1);
    waitIdle("soft_timeout", 60);
    checkOutput("soft_valid", {31'd0, frame_valid}, 32'd1);
    readCheck("soft_hdr", 6'd35, 32'h012E_FFA5);
    readCheck("soft_word3", 6'd3, 32'h0C00_0007);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
